// File: rtl/seq_divider8_if.sv
// Handshake and operand/result bundle for the sequential divider.
interface seq_divider8_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             div_zero;

    modport master (
        output start, a, b,
        input  busy, done, q, r, div_zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, q, r, div_zero
    );
endinterface

// File: rtl/seq_divider8.sv
// Multi-cycle unsigned restoring divider: one shift plus trial subtraction
// per clock, WIDTH iterations per result, start/busy/done handshake.
module seq_divider8 #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_divider8_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_dq;
    logic [WIDTH-1:0] r_dv;
    // The partial remainder's extra top bit is always 0 once restored
    // (a non-borrowing trial leaves t < divisor), so only WIDTH bits are kept.
    logic [WIDTH-1:0] r_pr;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_dz;

    logic [WIDTH:0]   w_s;
    logic [WIDTH:0]   w_t;
    logic [WIDTH-1:0] w_dq_nxt;
    logic [WIDTH-1:0] w_pr_nxt;
    logic             w_last;

    // Iteration datapath: shift in the next dividend bit, trial-subtract, restore on borrow.
    always_comb begin
        w_s      = {r_pr, r_dq[WIDTH-1]};
        w_t      = w_s - {1'b0, r_dv};
        w_dq_nxt = {r_dq[WIDTH-2:0], ~w_t[WIDTH]};
        w_pr_nxt = w_t[WIDTH] ? w_s[WIDTH-1:0] : w_t[WIDTH-1:0];
        w_last   = (r_state == RUN) && (r_cnt == LAST_ITER);
    end

    // Next-state decode; a zero divisor skips RUN and finishes immediately.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (bus.start) begin
                    w_state_nxt = (bus.b == '0) ? DONE : RUN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand capture, iteration registers and held results.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dq  <= '0;
            r_dv  <= '0;
            r_pr  <= '0;
            r_cnt <= '0;
            r_q   <= '0;
            r_r   <= '0;
            r_dz  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        r_dq  <= bus.a;
                        r_dv  <= bus.b;
                        r_pr  <= '0;
                        r_cnt <= '0;
                        if (bus.b == '0) begin
                            r_q  <= '1;
                            r_r  <= bus.a;
                            r_dz <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    r_dq  <= w_dq_nxt;
                    r_pr  <= w_pr_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_q  <= w_dq_nxt;
                        r_r  <= w_pr_nxt;
                        r_dz <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy     = (r_state == RUN);
    assign bus.done     = (r_state == DONE);
    assign bus.q        = r_q;
    assign bus.r        = r_r;
    assign bus.div_zero = r_dz;
endmodule
